// File: rtl/seven_segment_chain_ctrl.sv
// seven_segment_chain_ctrl: Avalon-MM digit register file that decodes one byte
// per digit and serialises the whole segment frame into a daisy chain of
// shift-register display drivers (ser_data / ser_clk / ser_latch).
module seven_segment_chain_ctrl #(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned CLK_DIV        = 4,
    parameter bit          ACTIVE_LOW_SEG = 1'b0,
    parameter int unsigned ADDR_W         = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              write,
    input  logic              read,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              ser_data,
    output logic              ser_clk,
    output logic              ser_latch,
    output logic              busy
);

    localparam int unsigned NUM_WORDS  = NUM_DIGITS / 4;
    localparam int unsigned FRAME_BITS = NUM_DIGITS * 8;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
    localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(FRAME_BITS - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(NUM_WORDS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        LATCH    = 3'd4
    } state_t;

    state_t                state_q, state_nxt;
    logic [DIV_W-1:0]      div_q, div_nxt;
    logic [BIT_W-1:0]      bit_q, bit_nxt;
    logic [FRAME_BITS-1:0] shbuf_q;
    logic [FRAME_BITS-1:0] frame_c;
    logic [FRAME_BITS-1:0] src_c;
    logic [7:0]            digit_q [NUM_DIGITS];
    logic                  pending_q;
    logic                  wr_digit_c;
    logic                  div_done_c;
    logic [31:0]           rd_c;
    logic                  ser_data_nxt;
    logic                  ser_clk_nxt;
    logic                  ser_latch_nxt;
    logic                  busy_nxt;

    // Digit byte -> shifted byte {dp,g,f,e,d,c,b,a}, optionally inverted.
    function automatic logic [7:0] encode_digit(input logic [7:0] d);
        logic [6:0] seg;
        logic       dp;
        seg = d[6:0];
        dp  = 1'b0;
        if (d[7]) begin
            dp = d[4];
            case (d[3:0])
                4'h0: seg = 7'h3F;
                4'h1: seg = 7'h06;
                4'h2: seg = 7'h5B;
                4'h3: seg = 7'h4F;
                4'h4: seg = 7'h66;
                4'h5: seg = 7'h6D;
                4'h6: seg = 7'h7D;
                4'h7: seg = 7'h07;
                4'h8: seg = 7'h7F;
                4'h9: seg = 7'h6F;
                4'hA: seg = 7'h77;
                4'hB: seg = 7'h7C;
                4'hC: seg = 7'h39;
                4'hD: seg = 7'h5E;
                4'hE: seg = 7'h79;
                default: seg = 7'h71;
            endcase
        end
        encode_digit = ACTIVE_LOW_SEG ? ~{dp, seg} : {dp, seg};
    endfunction

    assign wr_digit_c = write && (address < STATUS_ADDR) && (byteenable != 4'b0000);

    // Digit register file with per-lane byte enables.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                digit_q[d] <= 8'h00;
            end
        end else if (write) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                if (address == ADDR_W'(w)) begin
                    for (int i = 0; i < 4; i++) begin
                        if (byteenable[i]) begin
                            digit_q[4*w+i] <= writedata[8*i +: 8];
                        end
                    end
                end
            end
        end
    end

    // Pending refresh flag; a new write wins over the clear taken in LOAD.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= 1'b0;
        end else if (wr_digit_c) begin
            pending_q <= 1'b1;
        end else if (state_q == LOAD) begin
            pending_q <= 1'b0;
        end
    end

    // Read mux: digit words, status word, zero elsewhere.
    always_comb begin
        rd_c = 32'h0000_0000;
        if (address == STATUS_ADDR) begin
            rd_c = {30'd0, pending_q, busy};
        end
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (address == ADDR_W'(w)) begin
                rd_c = {digit_q[4*w+3], digit_q[4*w+2], digit_q[4*w+1], digit_q[4*w]};
            end
        end
    end

    // Registered read data, one cycle after the read strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            readdata <= 32'h0000_0000;
        end else if (read) begin
            readdata <= rd_c;
        end
    end

    // Decoded frame; the highest-index digit occupies the top byte.
    always_comb begin
        frame_c = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            frame_c[8*d +: 8] = encode_digit(digit_q[d]);
        end
    end

    // Next-state, counters and next output values for the serialiser.
    always_comb begin
        state_nxt     = state_q;
        div_nxt       = div_q;
        bit_nxt       = bit_q;
        div_done_c    = (div_q == DIV_LAST);
        src_c         = (state_q == LOAD) ? frame_c : shbuf_q;
        ser_data_nxt  = 1'b0;
        ser_clk_nxt   = 1'b0;
        ser_latch_nxt = 1'b0;
        busy_nxt      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = SHIFT_LO;
                div_nxt   = '0;
                bit_nxt   = LAST_BIT;
            end
            SHIFT_LO: begin
                if (div_done_c) begin
                    state_nxt = SHIFT_HI;
                    div_nxt   = '0;
                end else begin
                    div_nxt = div_q + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_done_c) begin
                    div_nxt = '0;
                    if (bit_q == '0) begin
                        state_nxt = LATCH;
                    end else begin
                        bit_nxt   = bit_q - 1'b1;
                        state_nxt = SHIFT_LO;
                    end
                end else begin
                    div_nxt = div_q + 1'b1;
                end
            end
            LATCH: begin
                if (div_done_c) begin
                    state_nxt = IDLE;
                    div_nxt   = '0;
                end else begin
                    div_nxt = div_q + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                div_nxt   = '0;
            end
        endcase

        busy_nxt      = (state_nxt != IDLE);
        ser_clk_nxt   = (state_nxt == SHIFT_HI);
        ser_latch_nxt = (state_nxt == LATCH);
        if ((state_nxt == SHIFT_LO) || (state_nxt == SHIFT_HI)) begin
            ser_data_nxt = src_c[bit_nxt];
        end
    end

    // State register, counters, snapshot buffer and registered chain outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            shbuf_q   <= '0;
            ser_data  <= 1'b0;
            ser_clk   <= 1'b0;
            ser_latch <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            div_q     <= div_nxt;
            bit_q     <= bit_nxt;
            if (state_q == LOAD) begin
                shbuf_q <= frame_c;
            end
            ser_data  <= ser_data_nxt;
            ser_clk   <= ser_clk_nxt;
            ser_latch <= ser_latch_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule
